victim_wb_drain: RTL and testbench
==================================

Name: victim_wb_drain

Overview:
- Reader/drain side of the victim cache storage; complements the enable-register writers that fill victim entries.
- On a flush request it walks all victim entries and reads each one.
- Each valid+dirty line is sent to memory over a valid/ready write handshake, then its dirty bit is cleared.
- Sits between the victim cache array and the memory write port; used on flush/context switch.

Parameters:
- ENTRIES, 8, number of victim entries; power of two, >= 2.
- IDX_W, 3, entry index width; must equal log2(ENTRIES).
- TAG_W, 61, line tag width.
- OFFSET_W, 3, byte offset bits appended as zeros to form the address.
- DATA_W, 64, line data width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush_start  in  1  request to begin a drain; accepted only in IDLE.
- busy  out  1  high from the cycle after acceptance until DONE completes.
- flush_done  out  1  one-cycle pulse when the walk is finished.
- wb_count  out  IDX_W+1  number of lines written back in the current or last drain.
- rd_en  out  1  read strobe to the victim array.
- rd_idx  out  IDX_W  entry index being read.
- rd_valid  in  1  entry valid bit; returned the cycle after rd_en.
- rd_dirty  in  1  entry dirty bit; same timing as rd_valid.
- rd_tag  in  TAG_W  entry tag; same timing as rd_valid.
- rd_data  in  DATA_W  entry data; same timing as rd_valid.
- mem_wr_valid  out  1  write request valid.
- mem_wr_ready  in  1  memory accepts the write when high together with mem_wr_valid.
- mem_addr  out  TAG_W+OFFSET_W  equals {tag, OFFSET_W'b0}.
- mem_data  out  DATA_W  line data to write.
- clean_en  out  1  one-cycle strobe to clear the dirty bit of entry clean_idx.
- clean_idx  out  IDX_W  entry whose dirty bit is cleared.

Behaviour:
- Reset: state IDLE, ptr=0, and every output 0 (busy, flush_done, wb_count, rd_en, rd_idx, mem_wr_valid, mem_addr, mem_data, clean_en, clean_idx).
- Reset takes priority over everything. Reset mid-drain returns to IDLE on that edge and drops mem_wr_valid on the same edge. Entries already cleaned stay clean; no resume.
- FSM states: IDLE, READ, EVAL, SEND, CLEAN, DONE.
- IDLE:
  - flush_start=1 → ptr=0, wb_count=0, go to READ.
  - flush_start is ignored in every other state.
- READ: rd_en=1, rd_idx=ptr for exactly one cycle → EVAL.
- EVAL: sample the rd_* inputs (1-cycle array read latency).
  - rd_valid & rd_dirty → capture tag and data into the output holding register → SEND.
  - Otherwise, ptr==ENTRIES-1 → DONE; else ptr+1 → READ.
- SEND:
  - mem_wr_valid=1; mem_addr and mem_data stay stable until the handshake.
  - On mem_wr_valid & mem_wr_ready → CLEAN, wb_count+1, mem_wr_valid deasserts the next cycle.
  - No timeout; mem_wr_ready may stay low indefinitely.
- CLEAN:
  - clean_en=1, clean_idx=ptr for one cycle.
  - Then ptr==ENTRIES-1 → DONE; else ptr+1 → READ.
- DONE: flush_done=1 for one cycle, busy=0 → IDLE.
- busy=1 in every state except IDLE and DONE.
- Arithmetic: ptr never wraps during a walk (the last-entry check happens before increment). wb_count max is ENTRIES and fits IDX_W+1 bits.
- wb_count holds its value after DONE until the next accepted flush_start.
- Latency:
  - Clean entry: 2 cycles (READ, EVAL).
  - Dirty entry: 4 cycles minimum (READ, EVAL, SEND with ready=1, CLEAN).
  - Empty drain: 2*ENTRIES+1 cycles from acceptance to the flush_done pulse.
- The victim array must not be written during a drain; collisions are the caller's responsibility.

Decomposition:
- Shared package victim_pkg holds: drain_state_t enum (IDLE, READ, EVAL, SEND, CLEAN, DONE), default ENTRIES, TAG_W, OFFSET_W, DATA_W constants.
- No new sub-module.
- The tag/data holding register is built from the existing width-parameterised enabled register, enabled in EVAL on a dirty hit.

Test Plan:
- All 8 entries invalid, flush_start pulse → no mem_wr_valid; flush_done 17 cycles after acceptance; wb_count=0.
- Entry 3 valid+dirty, tag=0x1234, data=0xDEADBEEF, mem_wr_ready=1 → mem_addr=0x91A0 and mem_data=0xDEADBEEF held one cycle; clean_en with clean_idx=3; wb_count=1.
- Entries 0, 5, 7 dirty, mem_wr_ready low for 4 cycles each → mem_wr_valid held 5 cycles per line with address/data stable; wb_count=3; entry 7 written last, then DONE.
- Valid but clean entry 2 → no write, no clean_en for index 2.
- flush_start reasserted while busy → ignored; a single flush_done pulse.
- Reset asserted in SEND → next cycle IDLE, mem_wr_valid=0, busy=0; a new flush_start restarts at rd_idx=0.

Source files
------------

// File: rtl/victim_pkg.sv
// Shared types and default geometry for the victim cache drain logic.
package victim_pkg;

  localparam int VICTIM_ENTRIES  = 8;
  localparam int VICTIM_TAG_W    = 61;
  localparam int VICTIM_OFFSET_W = 3;
  localparam int VICTIM_DATA_W   = 64;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EVAL,
    SEND,
    CLEAN,
    DONE
  } drain_state_t;

endpackage

// File: rtl/en_reg.sv
// Width-parameterised register with load enable and synchronous clear.
module en_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/victim_wb_drain.sv
// Victim cache drain: on a flush, walks every entry, writes valid+dirty lines
// to memory over a valid/ready port and then clears their dirty bits.
module victim_wb_drain
  import victim_pkg::*;
#(
  parameter int ENTRIES  = VICTIM_ENTRIES,
  parameter int IDX_W    = 3,
  parameter int TAG_W    = VICTIM_TAG_W,
  parameter int OFFSET_W = VICTIM_OFFSET_W,
  parameter int DATA_W   = VICTIM_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_start,
  output logic                      busy,
  output logic                      flush_done,
  output logic [IDX_W:0]            wb_count,
  output logic                      rd_en,
  output logic [IDX_W-1:0]          rd_idx,
  input  logic                      rd_valid,
  input  logic                      rd_dirty,
  input  logic [TAG_W-1:0]          rd_tag,
  input  logic [DATA_W-1:0]         rd_data,
  output logic                      mem_wr_valid,
  input  logic                      mem_wr_ready,
  output logic [TAG_W+OFFSET_W-1:0] mem_addr,
  output logic [DATA_W-1:0]         mem_data,
  output logic                      clean_en,
  output logic [IDX_W-1:0]          clean_idx
);

  // state | meaning
  // IDLE  | waiting for flush_start
  // READ  | rd_en strobe for entry ptr
  // EVAL  | array response sampled; a dirty hit is captured for write-back
  // SEND  | mem_wr_valid held until mem_wr_ready
  // CLEAN | clean_en strobe clears the dirty bit of entry ptr
  // DONE  | flush_done pulse, then back to IDLE

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  drain_state_t              state_q, state_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [IDX_W:0]            wb_count_q, wb_count_d;
  logic                      busy_q, busy_d;
  logic                      flush_done_q, flush_done_d;
  logic                      rd_en_q, rd_en_d;
  logic                      mem_wr_valid_q, mem_wr_valid_d;
  logic                      clean_en_q, clean_en_d;
  logic                      hold_en;
  logic                      last_entry;
  logic [TAG_W+DATA_W-1:0]   hold_q;

  assign last_entry = (ptr_q == LAST_IDX);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wb_count_d = wb_count_q;
    hold_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_start) begin
          ptr_d      = '0;
          wb_count_d = '0;
          state_d    = READ;
        end
      end
      READ: state_d = EVAL;
      EVAL: begin
        if (rd_valid && rd_dirty) begin
          hold_en = 1'b1;
          state_d = SEND;
        end else if (last_entry) begin
          state_d = DONE;
        end else begin
          ptr_d   = ptr_q + IDX_W'(1);
          state_d = READ;
        end
      end
      SEND: begin
        if (mem_wr_valid_q && mem_wr_ready) begin
          wb_count_d = wb_count_q + (IDX_W+1)'(1);
          state_d    = CLEAN;
        end
      end
      CLEAN: begin
        if (last_entry) begin
          state_d = DONE;
        end else begin
          ptr_d   = ptr_q + IDX_W'(1);
          state_d = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so they line up with it.
    busy_d         = (state_d != IDLE) && (state_d != DONE);
    flush_done_d   = (state_d == DONE);
    rd_en_d        = (state_d == READ);
    mem_wr_valid_d = (state_d == SEND);
    clean_en_d     = (state_d == CLEAN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      wb_count_q     <= '0;
      busy_q         <= 1'b0;
      flush_done_q   <= 1'b0;
      rd_en_q        <= 1'b0;
      mem_wr_valid_q <= 1'b0;
      clean_en_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      wb_count_q     <= wb_count_d;
      busy_q         <= busy_d;
      flush_done_q   <= flush_done_d;
      rd_en_q        <= rd_en_d;
      mem_wr_valid_q <= mem_wr_valid_d;
      clean_en_q     <= clean_en_d;
    end
  end

  en_reg #(.W(TAG_W + DATA_W)) u_hold (
    .clk  (clk),
    .reset(reset),
    .en   (hold_en),
    .d    ({rd_tag, rd_data}),
    .q    (hold_q)
  );

  assign busy         = busy_q;
  assign flush_done   = flush_done_q;
  assign wb_count     = wb_count_q;
  assign rd_en        = rd_en_q;
  assign rd_idx       = ptr_q;
  assign mem_wr_valid = mem_wr_valid_q;
  assign mem_addr     = {hold_q[TAG_W+DATA_W-1:DATA_W], {OFFSET_W{1'b0}}};
  assign mem_data     = hold_q[DATA_W-1:0];
  assign clean_en     = clean_en_q;
  assign clean_idx    = ptr_q;

endmodule

// File: tb/tb_victim_wb_drain.sv
// Self-checking bench for victim_wb_drain: directed vector table, random drains
// against a list-based reference model, and a reset-during-SEND sequence.
module tb_victim_wb_drain;

  localparam int ENTRIES  = 8;
  localparam int IDX_W    = 3;
  localparam int TAG_W    = 61;
  localparam int OFFSET_W = 3;
  localparam int DATA_W   = 64;
  localparam int AW       = TAG_W + OFFSET_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush_start = 1'b0;
  logic              busy, flush_done, rd_en, mem_wr_valid, clean_en;
  logic [IDX_W:0]    wb_count;
  logic [IDX_W-1:0]  rd_idx, clean_idx;
  logic              rd_valid = 1'b0, rd_dirty = 1'b0;
  logic [TAG_W-1:0]  rd_tag = '0;
  logic [DATA_W-1:0] rd_data = '0;
  logic              mem_wr_ready = 1'b0;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_data;

  always #5 clk = ~clk;

  victim_wb_drain dut (
    .clk(clk), .reset(reset), .flush_start(flush_start), .busy(busy),
    .flush_done(flush_done), .wb_count(wb_count), .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_dirty(rd_dirty), .rd_tag(rd_tag), .rd_data(rd_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .clean_en(clean_en), .clean_idx(clean_idx)
  );

  // Victim array contents, static during a drain.
  logic              arr_valid [ENTRIES];
  logic              arr_dirty [ENTRIES];
  logic [TAG_W-1:0]  arr_tag   [ENTRIES];
  logic [DATA_W-1:0] arr_data  [ENTRIES];
  int                stall_cfg = 0;

  // One-cycle read latency; junk on non-read cycles so stray sampling shows up.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_valid <= arr_valid[rd_idx];
      rd_dirty <= arr_dirty[rd_idx];
      rd_tag   <= arr_tag[rd_idx];
      rd_data  <= arr_data[rd_idx];
    end else begin
      rd_valid <= 1'($urandom_range(0, 1));
      rd_dirty <= 1'($urandom_range(0, 1));
      rd_tag   <= TAG_W'({$urandom(), $urandom()});
      rd_data  <= {$urandom(), $urandom()};
    end
  end

  // Memory side and event logs.
  logic [AW-1:0]     wr_addr_q [$];
  logic [DATA_W-1:0] wr_data_q [$];
  int                wr_len_q  [$];
  int                clean_q   [$];
  int                rd_q      [$];
  int                done_cnt = 0, busy_cyc = 0, stab_viol = 0, vcnt = 0;
  logic              prev_valid = 1'b0;
  logic [AW-1:0]     prev_addr = '0;
  logic [DATA_W-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (mem_wr_valid) begin
      if (prev_valid && (mem_addr !== prev_addr || mem_data !== prev_data)) stab_viol++;
      mem_wr_ready = (vcnt >= stall_cfg);
      vcnt++;
      if (mem_wr_ready) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_data);
        wr_len_q.push_back(vcnt);
      end
    end else begin
      mem_wr_ready = 1'($urandom_range(0, 1));
      vcnt = 0;
    end
    prev_valid = mem_wr_valid;
    prev_addr  = mem_addr;
    prev_data  = mem_data;
    if (clean_en)   clean_q.push_back(int'(clean_idx));
    if (rd_en)      rd_q.push_back(int'(rd_idx));
    if (flush_done) done_cnt++;
    if (busy)       busy_cyc++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_array(input logic [7:0] vmask, input logic [7:0] dmask);
    for (int i = 0; i < ENTRIES; i++) begin
      arr_valid[i] = vmask[i];
      arr_dirty[i] = dmask[i];
      arr_tag[i]   = TAG_W'({$urandom(), $urandom()});
      arr_data[i]  = {$urandom(), $urandom()};
    end
  endtask

  // Runs one drain and checks it against the reference model; exp_wb/exp_lat
  // of -1 skip the hand-computed table values.
  task automatic run_drain(input bit spam, input int exp_wb, input int exp_lat);
    int w0, c0, r0, d0, b0, s0, n;
    int m_wb, m_busy, j;
    int dirty_idx [$];
    w0 = wr_addr_q.size(); c0 = clean_q.size(); r0 = rd_q.size();
    d0 = done_cnt; b0 = busy_cyc; s0 = stab_viol;
    m_wb = 0; m_busy = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (arr_valid[i] && arr_dirty[i]) begin
        m_wb++;
        m_busy += 4 + stall_cfg;
        dirty_idx.push_back(i);
      end else begin
        m_busy += 2;
      end
    end

    @(negedge clk); flush_start = 1'b1;
    @(negedge clk); flush_start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
    n = 0;
    while (!flush_done && n < 2000) begin
      @(negedge clk);
      n++;
      if (spam) flush_start = 1'($urandom_range(0, 1));
    end
    flush_start = 1'b0;
    check("flush_done_seen", 64'(flush_done), 64'd1);
    repeat (3) @(negedge clk);

    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    check("wb_count_model", 64'(wb_count), 64'(m_wb));
    if (exp_wb >= 0)  check("wb_count_table", 64'(wb_count), 64'(exp_wb));
    check("latency_model", 64'(busy_cyc - b0 + done_cnt - d0), 64'(m_busy + 1));
    if (exp_lat >= 0) check("latency_table", 64'(busy_cyc - b0 + done_cnt - d0), 64'(exp_lat));
    check("write_count", 64'(wr_addr_q.size() - w0), 64'(m_wb));
    check("clean_count", 64'(clean_q.size() - c0), 64'(m_wb));
    for (int k = 0; k < dirty_idx.size(); k++) begin
      j = dirty_idx[k];
      if (w0 + k < wr_addr_q.size()) begin
        check("wr_addr", 64'(wr_addr_q[w0+k]), 64'({arr_tag[j], {OFFSET_W{1'b0}}}));
        check("wr_data", wr_data_q[w0+k], arr_data[j]);
        check("wr_valid_len", 64'(wr_len_q[w0+k]), 64'(stall_cfg + 1));
      end
      if (c0 + k < clean_q.size()) check("clean_idx", 64'(clean_q[c0+k]), 64'(j));
    end
    check("read_count", 64'(rd_q.size() - r0), 64'(ENTRIES));
    for (int k = 0; k < ENTRIES; k++)
      if (r0 + k < rd_q.size()) check("rd_idx_order", 64'(rd_q[r0+k]), 64'(k));
    check("addr_data_stable", 64'(stab_viol - s0), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    check("valid_after", 64'(mem_wr_valid), 64'd0);
  endtask

  task automatic check_all_zero();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_flush_done", 64'(flush_done), 64'd0);
    check("rst_wb_count", 64'(wb_count), 64'd0);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_rd_idx", 64'(rd_idx), 64'd0);
    check("rst_mem_wr_valid", 64'(mem_wr_valid), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_data", mem_data, 64'd0);
    check("rst_clean_en", 64'(clean_en), 64'd0);
    check("rst_clean_idx", 64'(clean_idx), 64'd0);
  endtask

  typedef struct {
    logic [7:0] vmask;
    logic [7:0] dmask;
    int         stall;
    bit         spam;
    int         exp_wb;
    int         exp_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n;
    vecs[0] = '{8'h00, 8'h00, 0, 1'b0, 0, 17};  // empty drain
    vecs[1] = '{8'h08, 8'h08, 0, 1'b0, 1, 19};  // entry 3 dirty
    vecs[2] = '{8'hA1, 8'hA1, 4, 1'b0, 3, 35};  // 0,5,7 dirty, 4 stall cycles
    vecs[3] = '{8'h44, 8'h40, 0, 1'b0, 1, 19};  // entry 2 valid but clean
    vecs[4] = '{8'hFF, 8'h0F, 1, 1'b1, 4, 29};  // flush_start spammed while busy
    vecs[5] = '{8'h0F, 8'hF0, 0, 1'b0, 0, 17};  // dirty but invalid never written

    set_array(8'h00, 8'h00);
    repeat (3) @(negedge clk);
    check_all_zero();
    reset = 1'b0;
    @(negedge clk);
    check_all_zero();

    for (int v = 0; v < 6; v++) begin
      set_array(vecs[v].vmask, vecs[v].dmask);
      if (v == 1) begin
        arr_tag[3]  = TAG_W'(64'h1234);
        arr_data[3] = 64'hDEADBEEF;
      end
      stall_cfg = vecs[v].stall;
      run_drain(vecs[v].spam, vecs[v].exp_wb, vecs[v].exp_lat);
      if (v == 1) begin
        check("entry3_addr", 64'(mem_addr), 64'h91A0);
        check("entry3_data", mem_data, 64'hDEADBEEF);
        check("entry3_clean", 64'(clean_q[clean_q.size()-1]), 64'd3);
      end
      if (v == 2) check("last_clean_is_7", 64'(clean_q[clean_q.size()-1]), 64'd7);
    end

    for (int r = 0; r < 6; r++) begin
      set_array(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      stall_cfg = $urandom_range(0, 3);
      run_drain(1'($urandom_range(0, 1)), -1, -1);
    end

    // Reset while a write is stalled in SEND.
    set_array(8'h02, 8'h02);
    stall_cfg = 1000;
    @(negedge clk); flush_start = 1'b1;
    @(negedge clk); flush_start = 1'b0;
    n = 0;
    while (!mem_wr_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_send", 64'(mem_wr_valid), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_send_valid", 64'(mem_wr_valid), 64'd0);
    check("rst_send_busy", 64'(busy), 64'd0);
    check("rst_send_wb", 64'(wb_count), 64'd0);
    reset = 1'b0;
    stall_cfg = 0;
    run_drain(1'b0, 1, 19);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
